// File: rtl/fourbit_acc_pkg.sv
// Shared types and default sizing for the 4-bit burst accumulator.
package fourbit_acc_pkg;

  localparam int DATA_W        = 4;
  localparam int DEF_BURST_LEN = 4;
  localparam int DEF_CNT_W     = 3;
  localparam int DEF_OVF_W     = 4;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ACCUM = 2'd1,
    DONE  = 2'd2
  } state_t;

endpackage

// File: rtl/fourbit_burst_accumulator_sat_counter.sv
// Saturating up-counter with synchronous clear; holds at all-ones.
module sat_counter #(
  parameter int W = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         clr,
  input  logic         inc,
  output logic [W-1:0] count
);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count <= '0;
    end else if (clr) begin
      count <= '0;
    end else if (inc && (count != {W{1'b1}})) begin
      count <= count + W'(1);
    end
  end

endmodule

// File: rtl/fourbit_burst_accumulator.sv
// Accumulates BURST_LEN operands through an external 4-bit adder and hands out one result per burst.
// Build option: FOURBIT_ACC_SATURATE_EN clamps the accumulator to 4'hF after the first adder carry.
module fourbit_burst_accumulator
  import fourbit_acc_pkg::*;
#(
  parameter int BURST_LEN = DEF_BURST_LEN,
  parameter int CNT_W     = DEF_CNT_W,
  parameter int OVF_W     = DEF_OVF_W
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              SOFT_CLR,
  input  logic              IN_VALID,
  output logic              IN_READY,
  input  logic [DATA_W-1:0] IN_DATA,
  output logic [DATA_W-1:0] ADD_A,
  output logic [DATA_W-1:0] ADD_B,
  input  logic [DATA_W-1:0] ADD_SUM,
  input  logic              ADD_COUT,
  output logic              OUT_VALID,
  input  logic              OUT_READY,
  output logic [DATA_W-1:0] OUT_SUM,
  output logic [OVF_W-1:0]  OUT_OVF
);

  state_t            state;
  logic [DATA_W-1:0] acc;
  logic [DATA_W-1:0] acc_next;
  logic [CNT_W-1:0]  cnt;
  logic [OVF_W-1:0]  ovf;
  logic              accept;
  logic              last;
  logic              release_done;

  assign IN_READY     = ~RST & (state != DONE);
  assign accept       = IN_VALID & IN_READY;
  assign last         = (cnt == CNT_W'(BURST_LEN - 1));
  assign release_done = (state == DONE) & OUT_READY;

  assign ADD_A = acc;
  assign ADD_B = IN_DATA;

  // Result is only visible while it is being offered.
  assign OUT_SUM = OUT_VALID ? acc : '0;
  assign OUT_OVF = OUT_VALID ? ovf : '0;

`ifdef FOURBIT_ACC_SATURATE_EN
  logic sat;
  assign acc_next = (sat | ADD_COUT) ? {DATA_W{1'b1}} : ADD_SUM;
`else
  assign acc_next = ADD_SUM;
`endif

  sat_counter #(.W(OVF_W)) u_ovf_cnt (
    .clk   (CLK),
    .rst   (RST),
    .clr   (SOFT_CLR | release_done),
    .inc   (accept & ADD_COUT & ~SOFT_CLR),
    .count (ovf)
  );

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state     <= IDLE;
      acc       <= '0;
      cnt       <= '0;
      OUT_VALID <= 1'b0;
`ifdef FOURBIT_ACC_SATURATE_EN
      sat       <= 1'b0;
`endif
    end else if (SOFT_CLR) begin
      state     <= IDLE;
      acc       <= '0;
      cnt       <= '0;
      OUT_VALID <= 1'b0;
`ifdef FOURBIT_ACC_SATURATE_EN
      sat       <= 1'b0;
`endif
    end else begin
      case (state)
        IDLE, ACCUM: begin
          if (accept) begin
            acc <= acc_next;
            cnt <= cnt + CNT_W'(1);
`ifdef FOURBIT_ACC_SATURATE_EN
            if (ADD_COUT) sat <= 1'b1;
`endif
            if (last) begin
              state     <= DONE;
              OUT_VALID <= 1'b1;
            end else begin
              state <= ACCUM;
            end
          end
        end
        DONE: begin
          if (OUT_READY) begin
            state     <= IDLE;
            acc       <= '0;
            cnt       <= '0;
            OUT_VALID <= 1'b0;
`ifdef FOURBIT_ACC_SATURATE_EN
            sat       <= 1'b0;
`endif
          end
        end
        default: begin
          state     <= IDLE;
          acc       <= '0;
          cnt       <= '0;
          OUT_VALID <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_fourbit_burst_accumulator.sv
// Directed bench for fourbit_burst_accumulator; the external ripple adder is modelled here.
module tb_fourbit_burst_accumulator;

  logic       CLK = 1'b0;
  logic       RST;
  logic       SOFT_CLR;
  logic       IN_VALID;
  logic       IN_READY;
  logic [3:0] IN_DATA;
  logic [3:0] ADD_A;
  logic [3:0] ADD_B;
  logic [3:0] ADD_SUM;
  logic       ADD_COUT;
  logic       OUT_VALID;
  logic       OUT_READY;
  logic [3:0] OUT_SUM;
  logic [3:0] OUT_OVF;

  int total = 0;
  int bad   = 0;

  always #5 CLK = ~CLK;

  assign {ADD_COUT, ADD_SUM} = {1'b0, ADD_A} + {1'b0, ADD_B};

  fourbit_burst_accumulator dut (
    .CLK       (CLK),
    .RST       (RST),
    .SOFT_CLR  (SOFT_CLR),
    .IN_VALID  (IN_VALID),
    .IN_READY  (IN_READY),
    .IN_DATA   (IN_DATA),
    .ADD_A     (ADD_A),
    .ADD_B     (ADD_B),
    .ADD_SUM   (ADD_SUM),
    .ADD_COUT  (ADD_COUT),
    .OUT_VALID (OUT_VALID),
    .OUT_READY (OUT_READY),
    .OUT_SUM   (OUT_SUM),
    .OUT_OVF   (OUT_OVF)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  // Presents one operand for exactly one clock; IN_READY must already be high.
  task automatic send(input logic [3:0] d);
    IN_VALID = 1'b1;
    IN_DATA  = d;
    check("in_ready_before_send", IN_READY, 1);
    check("add_b_passthrough", ADD_B, d);
    step();
    IN_VALID = 1'b0;
  endtask

  task automatic check_result(input string tag, input logic [3:0] sum, input logic [3:0] ovf);
    check({tag, "_valid"}, OUT_VALID, 1);
    check({tag, "_sum"}, OUT_SUM, sum);
    check({tag, "_ovf"}, OUT_OVF, ovf);
    check({tag, "_in_ready"}, IN_READY, 0);
  endtask

  task automatic check_idle(input string tag);
    check({tag, "_valid"}, OUT_VALID, 0);
    check({tag, "_sum"}, OUT_SUM, 0);
    check({tag, "_ovf"}, OUT_OVF, 0);
    check({tag, "_in_ready"}, IN_READY, 1);
    check({tag, "_acc"}, ADD_A, 0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [3:0] ff_acc [4];
    logic [3:0] ff_sum;
`ifdef FOURBIT_ACC_SATURATE_EN
    ff_acc = '{4'hF, 4'hF, 4'hF, 4'hF};
    ff_sum = 4'hF;
`else
    ff_acc = '{4'hF, 4'hE, 4'hD, 4'hC};
    ff_sum = 4'hC;
`endif

    RST       = 1'b1;
    SOFT_CLR  = 1'b0;
    IN_VALID  = 1'b0;
    IN_DATA   = 4'h0;
    OUT_READY = 1'b1;

    #2;
    check("rst_in_ready", IN_READY, 0);
    check("rst_out_valid", OUT_VALID, 0);
    check("rst_out_sum", OUT_SUM, 0);
    check("rst_out_ovf", OUT_OVF, 0);
    check("rst_acc", ADD_A, 0);
    #10 RST = 1'b0;
    step();
    check_idle("post_rst");

    // back-to-back 1,2,3,4
    send(4'h1); check("b2b_acc1", ADD_A, 4'h1);
    check("b2b_no_early_valid", OUT_VALID, 0);
    send(4'h2); check("b2b_acc2", ADD_A, 4'h3);
    send(4'h3); check("b2b_acc3", ADD_A, 4'h6);
    send(4'h4);
    check_result("b2b", 4'hA, 4'h0);
    step();
    check_idle("b2b_after");

    // F,F,F,F: wrap or saturate depending on build
    for (int i = 0; i < 4; i++) begin
      send(4'hF);
      check("ff_acc", ADD_A, ff_acc[i]);
    end
    check_result("ff", ff_sum, 4'h3);
    step();
    check_idle("ff_after");

    // DONE held for 5 cycles with operands offered
    OUT_READY = 1'b0;
    for (int i = 0; i < 4; i++) send(4'h1);
    check_result("hold_enter", 4'h4, 4'h0);
    IN_VALID = 1'b1;
    IN_DATA  = 4'h9;
    for (int i = 0; i < 5; i++) begin
      step();
      check_result("hold", 4'h4, 4'h0);
      check("hold_acc", ADD_A, 4'h4);
    end
    IN_VALID  = 1'b0;
    OUT_READY = 1'b1;
    check_result("hold_release_cycle", 4'h4, 4'h0);
    step();
    check_idle("hold_after");

    // abort a partial burst with SOFT_CLR, dropping the concurrent operand
    send(4'h3);
    send(4'h5);
    check("sclr_partial_acc", ADD_A, 4'h8);
    SOFT_CLR = 1'b1;
    IN_VALID = 1'b1;
    IN_DATA  = 4'h7;
    step();
    SOFT_CLR = 1'b0;
    IN_VALID = 1'b0;
    check_idle("sclr_after");
    for (int i = 0; i < 3; i++) begin
      send(4'h1);
      check("sclr_no_result", OUT_VALID, 0);
    end
    send(4'h1);
    check_result("sclr_burst", 4'h4, 4'h0);
    step();

    // SOFT_CLR discards an unconsumed result
    OUT_READY = 1'b0;
    for (int i = 0; i < 4; i++) send(4'h2);
    check_result("sclr_done_enter", 4'h8, 4'h0);
    SOFT_CLR = 1'b1;
    step();
    SOFT_CLR  = 1'b0;
    OUT_READY = 1'b1;
    check_idle("sclr_done_after");

    // asynchronous reset between edges mid-burst
    send(4'h7);
    send(4'h7);
    check("rst_mid_acc", ADD_A, 4'hE);
    #2 RST = 1'b1;
    #1;
    check("rst_mid_acc_zero", ADD_A, 0);
    check("rst_mid_in_ready", IN_READY, 0);
    check("rst_mid_out_valid", OUT_VALID, 0);
    check("rst_mid_out_sum", OUT_SUM, 0);
    check("rst_mid_out_ovf", OUT_OVF, 0);
    #1 RST = 1'b0;
    step();
    check_idle("rst_mid_after");
    for (int i = 0; i < 4; i++) send(4'h2);
    check_result("rst_burst", 4'h8, 4'h0);
    step();

    // operands with idle gaps; the unused IN_DATA still reaches ADD_B
    send(4'h1);
    IN_DATA = 4'hD;
    #1;
    check("gap_add_b", ADD_B, 4'hD);
    step();
    check("gap1_acc_hold", ADD_A, 4'h1);
    send(4'h2);
    IN_DATA = 4'h6;
    step();
    step();
    check("gap2_acc_hold", ADD_A, 4'h3);
    check("gap2_add_b", ADD_B, 4'h6);
    check("gap2_no_valid", OUT_VALID, 0);
    send(4'h3);
    step();
    check("gap3_acc_hold", ADD_A, 4'h6);
    send(4'h4);
    check_result("gap", 4'hA, 4'h0);
    step();
    check_idle("gap_after");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/fourbit_burst_accumulator.md
Name: fourbit_burst_accumulator

Overview:
- Sequential stage wrapped around the combinational 4-bit ripple adder.
- Feeds the adder's A/B operands and consumes its SUM/COUT, accumulating a burst of BURST_LEN 4-bit operands.
- Presents one registered result plus a carry-out count per burst.
- Valid/ready handshakes on both sides; the adder itself is instantiated outside this block.

Parameters:
- BURST_LEN, 4: operands summed per result; legal range 1..2**CNT_W.
- CNT_W, 3: width of the internal operand counter.
- OVF_W, 4: width of OUT_OVF carry counter.

Ports:
- CLK  in  1  single clock, rising edge.
- RST  in  1  asynchronous, active-high reset.
- SOFT_CLR  in  1  synchronous burst abort/clear.
- IN_VALID  in  1  operand valid.
- IN_READY  out  1  block accepts operand.
- IN_DATA  in  4  operand.
- ADD_A  out  4  to adder A: the accumulator register.
- ADD_B  out  4  to adder B: IN_DATA passthrough.
- ADD_SUM  in  4  from adder SUM.
- ADD_COUT  in  1  from adder COUT.
- OUT_VALID  out  1  result valid.
- OUT_READY  in  1  consumer accepts result.
- OUT_SUM  out  4  accumulated burst sum.
- OUT_OVF  out  OVF_W  number of adder carries in the burst.

Behaviour:
- Interface: one clock CLK; RST asynchronous, active-high.
- Reset: state=IDLE; acc, cnt, ovf = 0; OUT_VALID=0; OUT_SUM=0; OUT_OVF=0; IN_READY=0 while RST is high.
- Asserting RST mid-burst discards all partial state immediately, without waiting for a clock edge.
- Adder path is combinational: ADD_A=acc and ADD_B=IN_DATA in every cycle.
- An accept (IN_VALID && IN_READY) registers acc<=ADD_SUM and ovf<=ovf+ADD_COUT; ovf saturates at all-ones.
- States:
  - IDLE: IN_READY=1, cnt=0, acc=0. On accept, go to DONE if BURST_LEN==1, else to ACCUM with cnt=1.
  - ACCUM: IN_READY=1. On accept, cnt++. If the accepted operand is number BURST_LEN (cnt==BURST_LEN-1 before the increment), go to DONE.
  - DONE: IN_READY=0; IN_VALID is ignored. OUT_VALID=1, OUT_SUM=acc, OUT_OVF=ovf, all stable until OUT_READY.
  - DONE with OUT_READY=1: next cycle go to IDLE, clear acc/cnt/ovf, OUT_VALID=0.
- Latency: OUT_VALID rises on the cycle after the last operand is accepted.
- Minimum burst period: BURST_LEN+1 cycles.
- IN_VALID gaps: state holds, and acc/cnt/ovf are unchanged.
- SOFT_CLR: highest synchronous priority. Next state is IDLE with acc/cnt/ovf cleared and OUT_VALID=0. An operand presented in the same cycle is dropped, and an unconsumed DONE result is discarded.
- Arithmetic: 4-bit wrap; the carry is only counted.
- OUT_SUM/OUT_OVF read 0 whenever OUT_VALID=0.

Optional Feature:
- Macro: FOURBIT_ACC_SATURATE_EN.
- Defined: an accept with ADD_COUT=1 loads acc<=4'hF and sets a sticky sat flag. While sat is set, acc stays 4'hF for the rest of the burst. The carry count is unchanged. The flag clears with acc.
- Undefined: acc<=ADD_SUM always (wrap).

Decomposition:
- Shared package fourbit_acc_pkg:
  - DATA_W=4 constant.
  - state_t enum {IDLE, ACCUM, DONE}.
  - Default BURST_LEN/CNT_W/OVF_W constants.
- One natural sub-module, sat_counter: parameterised width, synchronous clear, increment enable, saturating at max; used for ovf.
- Adder stays external to this block.

Test Plan:
- Back-to-back operands 1,2,3,4 with OUT_READY=1: OUT_VALID one cycle after 4th accept; OUT_SUM=4'hA, OUT_OVF=0; IDLE on the following cycle.
- Operands F,F,F,F, macro off: acc F,E,D,C; OUT_SUM=4'hC, OUT_OVF=3. Macro on: OUT_SUM=4'hF, OUT_OVF=3.
- DONE with OUT_READY=0 for 5 cycles while IN_VALID=1: OUT_VALID held, OUT_SUM stable, IN_READY=0, no operand consumed; result released on the OUT_READY cycle.
- Operands 3,5, then SOFT_CLR, then burst 1,1,1,1: OUT_SUM=4'h4, OUT_OVF=0; no result emitted for the aborted burst.
- RST pulsed between clock edges after operands 7,7: all outputs 0 immediately; after release, burst 2,2,2,2 gives OUT_SUM=4'h8.
- Operands 1,2,3,4 with idle cycles interleaved: same result as back-to-back; ADD_A equals acc and ADD_B equals IN_DATA every cycle.
